mavg_filter_param: RTL and testbench
====================================

Name: mavg_filter_param

Overview:
Parametrised successor to the fixed 10-bit moving-average master. Takes sample-rate strobed samples and produces a boxcar (moving) average over a runtime-selectable power-of-two window. Uses a circular sample buffer and a running sum. Sits between the sample input pins (data plus strobe) and the output pins, with a one-cycle output strobe per averaged sample.

Parameters:
DATA_W, 10, sample and output width (unsigned).
MIN_LOG2_DEPTH, 1, log2 of the smallest window (win_sel=0).
MAX_LOG2_DEPTH, 4, log2 of the buffer depth and the largest window; window log2 = min(MIN_LOG2_DEPTH+win_sel, MAX_LOG2_DEPTH).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  block enable; 0 freezes FSM and sum, forces strobe_out=0
data_in  in  DATA_W  sample; stable from strobe_in rise for at least 3 clk cycles
strobe_in  in  1  level sample clock from pins; each rising edge is one new sample
win_sel  in  2  window select: N = 2^(window log2)
data_out  out  DATA_W  latest average
strobe_out  out  1  one-cycle pulse, data_out updated
busy  out  1  high while buffer is being cleared; strobes are dropped

Behaviour:
- Reset (async, rst_n=0): data_out=0, strobe_out=0, busy=1, sum=0, wr_ptr=0, edge-sync flops=0, state=CLEAR, clr_cnt=0.
- Edge detect: strobe_in passes through 2 sync flops (s1, s2) plus a delay flop s3. Edge = s2 & ~s3.
- Buffer: 2^MAX_LOG2_DEPTH x DATA_W, no reset, written only by the FSM. Sum width is DATA_W+MAX_LOG2_DEPTH, unsigned, never negative and never overflows.
- CLEAR: writes 0 to buf[clr_cnt], increments clr_cnt; sum=0; busy=1. Exits to IDLE after 2^MAX_LOG2_DEPTH cycles with wr_ptr=0 and busy=0. data_out holds its value.
- IDLE:
  - If registered win_sel differs from the new win_sel, capture the new value and go to CLEAR.
  - Else if edge, latch data_in into new_r, compute rd_ptr = wr_ptr - N (mod depth), and go to READ.
  - A win_sel change and an edge in the same cycle: CLEAR wins and the sample is dropped.
- READ: old_r = buf[rd_ptr] (synchronous-read friendly). Go to UPDATE.
- UPDATE: sum = sum + new_r - old_r; buf[wr_ptr] = new_r; wr_ptr increments, wrapping at depth. Go to OUT.
- OUT: data_out = sum >> log2N (truncate); strobe_out=1 for exactly this one registered cycle. Go to IDLE.
- Latency: strobe_in first sampled high at clk edge k gives strobe_out high after edge k+5, for 1 cycle. data_in is sampled at edge k+2.
- Throughput: one sample per 4 FSM cycles. An edge arriving outside IDLE is lost.
- Warm-up: the buffer is zeroed, so the first N-1 outputs are zero-padded averages. No special casing.
- win_sel is sampled only in IDLE. A change mid-operation takes effect after the current OUT.
- ena=0: state, sum, pointers and data_out hold; edges detected while ena=0 are discarded; strobe_out=0. Sync flops keep running.
- rst_n asserted mid-operation: immediate return to reset values, then a full CLEAR.

Optional Feature:
Macro MAVG_ROUND_EN.
- Defined: OUT computes (sum + 2^(log2N-1)) >> log2N, i.e. round half up. The add is done at sum width +1, and the result saturates at 2^DATA_W-1.
- Undefined: plain truncation. No extra adder is generated.

Decomposition:
- Package mavg_pkg holds:
  - state enum {CLEAR, IDLE, READ, UPDATE, OUT};
  - function win_log2(win_sel, MIN, MAX);
  - localparam SUM_W = DATA_W + MAX_LOG2_DEPTH.
- Sub-module mavg_edge_sync: 2-flop synchroniser plus rising-edge pulse, async active-low reset on clk/rst_n.
- Buffer is an inferred array inside the top. No separate RAM module.

Test Plan:
1. Reset pulse, then release -> busy=1 for exactly 16 cycles, data_out=0, strobe_out=0, then busy=0.
2. win_sel=0 (N=2); samples 100, 200, 300 -> data_out 50, 150, 250; each strobe_out is 1 cycle wide, 5 cycles after the strobe_in rise.
3. win_sel=1 (N=4); four samples of 1023 -> data_out 255, 511, 767, 1023; fifth sample 0 -> 767.
4. win_sel changed 1->3 mid-stream -> busy for 16 cycles; a strobe during busy produces no strobe_out; next sample 800 gives 50 (800/16).
5. N=2; samples 0, 1 -> second output is 0 without MAVG_ROUND_EN and 1 with it; with it, 1023, 1023 gives 1023 (no wrap).
6. ena=0 with strobes applied -> no strobe_out and sum unchanged. Then rst_n pulsed during UPDATE -> data_out=0, busy=1 immediately.

Source files
------------

// File: rtl/mavg_pkg.sv
// Shared types and helpers for the parametrised moving-average filter.
package mavg_pkg;

    localparam int DEF_DATA_W         = 10;
    localparam int DEF_MIN_LOG2_DEPTH = 1;
    localparam int DEF_MAX_LOG2_DEPTH = 4;
    localparam int SUM_W              = DEF_DATA_W + DEF_MAX_LOG2_DEPTH;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        UPDATE,
        OUT
    } state_t;

    // Window log2 grows with win_sel but is capped at the buffer depth.
    function automatic int win_log2(input logic [1:0] sel, input int min_l2, input int max_l2);
        int sum_l2;
        sum_l2 = min_l2 + int'(sel);
        return (sum_l2 > max_l2) ? max_l2 : sum_l2;
    endfunction

endpackage

// File: rtl/mavg_edge_sync.sv
// Two-flop synchroniser for the pin-level sample strobe, plus a delay flop
// that turns each rising edge into a single-cycle pulse.
module mavg_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strobe_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/mavg_filter_param.sv
// Boxcar moving average over a runtime-selectable power-of-two window.
// Define MAVG_ROUND_EN to round half up (saturating) instead of truncating.
module mavg_filter_param
    import mavg_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MIN_LOG2_DEPTH = DEF_MIN_LOG2_DEPTH,
    parameter int MAX_LOG2_DEPTH = DEF_MAX_LOG2_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe_in,
    input  logic [1:0]        win_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              busy
);

    localparam int DEPTH    = 1 << MAX_LOG2_DEPTH;
    localparam int PTR_W    = MAX_LOG2_DEPTH;
    localparam int SUM_BITS = DATA_W + MAX_LOG2_DEPTH;

    state_t state;
    state_t state_next;

    logic                rise;
    logic [DATA_W-1:0]   sample_mem [DEPTH];
    logic [SUM_BITS-1:0] sum;
    logic [SUM_BITS-1:0] sum_next;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    clr_cnt;
    logic [1:0]          win_sel_r;
    logic [DATA_W-1:0]   new_r;
    logic [DATA_W-1:0]   old_r;
    logic [DATA_W-1:0]   avg;
    logic [PTR_W:0]      n_full;
    int                  log2n;

    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    mavg_edge_sync u_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_in (strobe_in),
        .rise      (rise)
    );

    always_comb begin
        log2n    = win_log2(win_sel_r, MIN_LOG2_DEPTH, MAX_LOG2_DEPTH);
        n_full   = (PTR_W+1)'(1) << log2n;
        sum_next = sum + SUM_BITS'(new_r) - SUM_BITS'(old_r);
    end

`ifdef MAVG_ROUND_EN
    logic [SUM_BITS:0] half;
    logic [SUM_BITS:0] rnd_sum;
    logic [SUM_BITS:0] rnd_shift;

    // One extra bit keeps the rounding add from wrapping before the clamp.
    always_comb begin
        half      = (SUM_BITS+1)'(1) << (log2n - 1);
        rnd_sum   = {1'b0, sum} + half;
        rnd_shift = rnd_sum >> log2n;
        if (rnd_shift > {{(SUM_BITS+1-DATA_W){1'b0}}, {DATA_W{1'b1}}}) begin
            avg = '1;
        end else begin
            avg = DATA_W'(rnd_shift);
        end
    end
`else
    always_comb begin
        avg = DATA_W'(sum >> log2n);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (&clr_cnt) state_next = IDLE;
            IDLE: begin
                if (win_sel != win_sel_r) begin
                    state_next = CLEAR;
                end else if (rise) begin
                    state_next = READ;
                end
            end
            READ:    state_next = UPDATE;
            UPDATE:  state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    // Datapath registers advance only with the FSM; strobe_out is a single registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            clr_cnt    <= '0;
            win_sel_r  <= '0;
            new_r      <= '0;
            old_r      <= '0;
            data_out   <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            if (ena) begin
                case (state)
                    CLEAR: begin
                        sum     <= '0;
                        clr_cnt <= clr_cnt + 1'b1;
                        if (&clr_cnt) wr_ptr <= '0;
                    end
                    IDLE: begin
                        if (win_sel != win_sel_r) begin
                            win_sel_r <= win_sel;
                            clr_cnt   <= '0;
                        end else if (rise) begin
                            new_r  <= data_in;
                            rd_ptr <= wr_ptr - PTR_W'(n_full);
                        end
                    end
                    READ: begin
                        old_r <= sample_mem[rd_ptr];
                    end
                    UPDATE: begin
                        sum    <= sum_next;
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    OUT: begin
                        data_out   <= avg;
                        strobe_out <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mem_we    = ena && ((state == CLEAR) || (state == UPDATE));
        mem_waddr = (state == CLEAR) ? clr_cnt : wr_ptr;
        mem_wdata = (state == CLEAR) ? '0 : new_r;
    end

    // Sample buffer carries no reset; CLEAR zeroes it after every reset or window change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            sample_mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mavg_filter_param.sv
// Directed bench for mavg_filter_param with an expected-value scoreboard.
// Expected averages follow MAVG_ROUND_EN when the bench is built with it.
module tb_mavg_filter_param;

`ifdef MAVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [9:0] data_in;
    logic       strobe_in;
    logic [1:0] win_sel;
    logic [9:0] data_out;
    logic       strobe_out;
    logic       busy;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int stim_cyc = 0;
    int busy_n;
    logic [9:0] exp_q [$];

    mavg_filter_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .win_sel    (win_sel),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample and queue the average it should produce.
    task automatic applyStimulus(input logic [9:0] value, input logic [9:0] expected);
        @(negedge clk);
        data_in   = value;
        strobe_in = 1'b1;
        stim_cyc  = cyc;
        exp_q.push_back(expected);
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
    endtask

    task automatic pulseStrobe(input logic [9:0] value);
        @(negedge clk);
        data_in   = value;
        strobe_in = 1'b1;
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
    endtask

    // Wait for the output strobe, then check latency, value and pulse width.
    task automatic checkOutput(input string tag);
        bit         seen;
        int         lat;
        logic [9:0] exp_v;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobe_out === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - stim_cyc;
                break;
            end
        end
        exp_v = exp_q.pop_front();
        checkValue({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkValue({tag, "_latency"}, 32'(lat), 32'd6);
            checkValue({tag, "_data"}, 32'(data_out), 32'(exp_v));
            @(negedge clk);
            checkValue({tag, "_width"}, 32'(strobe_out), 32'd0);
        end
    endtask

    // Count cycles with busy high from the current negedge; optionally poke a strobe meanwhile.
    task automatic countBusy(input string tag, input bit poke);
        bit saw;
        busy_n = 0;
        saw    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (poke && i == 2) begin
                data_in   = 10'd777;
                strobe_in = 1'b1;
            end
            if (poke && i == 6) strobe_in = 1'b0;
            if (strobe_out === 1'b1) saw = 1'b1;
            if (busy !== 1'b1) break;
            busy_n++;
            @(negedge clk);
        end
        strobe_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (strobe_out === 1'b1) saw = 1'b1;
        end
        checkValue({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
        checkValue({tag, "_no_strobe"}, 32'(saw), 32'd0);
    endtask

    initial begin
        bit saw_out;
        rst_n     = 1'b0;
        ena       = 1'b1;
        data_in   = '0;
        strobe_in = 1'b0;
        win_sel   = 2'd0;

        // Reset state and the initial 16-cycle clear
        repeat (3) @(negedge clk);
        checkValue("reset_busy", 32'(busy), 32'd1);
        checkValue("reset_data_out", 32'(data_out), 32'd0);
        checkValue("reset_strobe_out", 32'(strobe_out), 32'd0);
        rst_n = 1'b1;
        countBusy("init_clear", 1'b0);
        checkValue("init_data_out", 32'(data_out), 32'd0);

        // N=2
        applyStimulus(10'd100, 10'd50);
        checkOutput("n2_s100");
        applyStimulus(10'd200, 10'd150);
        checkOutput("n2_s200");
        applyStimulus(10'd300, 10'd250);
        checkOutput("n2_s300");

        // N=4, full-scale samples
        win_sel = 2'd1;
        @(negedge clk);
        countBusy("sel1_clear", 1'b0);
        applyStimulus(10'd1023, ROUND ? 10'd256 : 10'd255);
        checkOutput("n4_a");
        applyStimulus(10'd1023, ROUND ? 10'd512 : 10'd511);
        checkOutput("n4_b");
        applyStimulus(10'd1023, 10'd767);
        checkOutput("n4_c");
        applyStimulus(10'd1023, 10'd1023);
        checkOutput("n4_d");
        applyStimulus(10'd0, 10'd767);
        checkOutput("n4_e");

        // Window change mid-sample takes effect after OUT; strobes during clear are dropped
        applyStimulus(10'd512, ROUND ? 10'd640 : 10'd639);
        win_sel = 2'd3;
        checkOutput("n4_midchange");
        countBusy("sel3_clear", 1'b1);
        applyStimulus(10'd800, 10'd50);
        checkOutput("n16_s800");

        // N=2 rounding behaviour and no wrap at full scale
        win_sel = 2'd0;
        @(negedge clk);
        countBusy("sel0_clear", 1'b0);
        applyStimulus(10'd0, 10'd0);
        checkOutput("rnd_s0");
        applyStimulus(10'd1, ROUND ? 10'd1 : 10'd0);
        checkOutput("rnd_s1");
        applyStimulus(10'd1023, 10'd512);
        checkOutput("rnd_s1023a");
        applyStimulus(10'd1023, 10'd1023);
        checkOutput("rnd_s1023b");

        // ena=0 drops strobes and holds state
        ena = 1'b0;
        pulseStrobe(10'd900);
        saw_out = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (strobe_out === 1'b1) saw_out = 1'b1;
        end
        checkValue("ena0_no_strobe", 32'(saw_out), 32'd0);
        checkValue("ena0_data_hold", 32'(data_out), 32'd1023);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(10'd1, 10'd512);
        checkOutput("ena1_sum_kept");

        // Reset asserted while the FSM is in UPDATE
        pulseStrobe(10'd900);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("midrst_data_out", 32'(data_out), 32'd0);
        checkValue("midrst_busy", 32'(busy), 32'd1);
        checkValue("midrst_strobe_out", 32'(strobe_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countBusy("midrst_clear", 1'b0);
        applyStimulus(10'd600, 10'd300);
        checkOutput("post_rst_s600");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
